// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC frame uplink
package adc_pkg;

  localparam int unsigned ADC_W      = 8;
  localparam int unsigned FIFO_DEPTH = 4096;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, HDR, RD, CAP, SEND, TAIL, FLUSH, REARM
  } state_t;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/adc_frame_uplink_uart.sv
// rtl/adc_frame_uplink_uart.sv - UART 8N1 byte transmitter
module uart_byte_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    sh_q, sh_d;
  logic          line_q, line_d;

  // Bit 0 is the start bit, bits 1..8 data LSB first, bit 9 the stop bit.
  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    line_d = line_q;
    if (!busy_q) begin
      if (tx_start) begin
        busy_d = 1'b1;
        div_d  = '0;
        bit_d  = 4'd0;
        sh_d   = {1'b1, tx_data};
        line_d = 1'b0;
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        line_d = 1'b1;
      end else begin
        line_d = sh_q[0];
        sh_d   = {1'b1, sh_q[8:1]};
        bit_d  = bit_q + 4'd1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Transmitter state registers; line idles high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= 4'd0;
      sh_q   <= '1;
      line_q <= 1'b1;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      line_q <= line_d;
    end
  end

  // Done fires in the last stop-bit cycle so the next byte can follow closely.
  assign tx_done = busy_q && (bit_q == 4'd9) && (div_q == DIV_LAST);
  assign tx_busy = busy_q;
  assign uart_tx = line_q;

endmodule

// File: rtl/adc_frame_uplink.sv
// rtl/adc_frame_uplink.sv - drains the capture FIFO and ships one UART frame
module adc_frame_uplink
  import adc_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned FRAME_LEN = FIFO_DEPTH,
  parameter logic [7:0]  CH_ID     = 8'h00,
  parameter logic [7:0]  SYNC      = SYNC_BYTE
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ADC_end,
  input  logic             empty,
  input  logic [ADC_W-1:0] fifo_q,
  output logic             rdreq,
  output logic             ADC_bg,
  output logic             uart_tx,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam logic [15:0] LEN16    = 16'(FRAME_LEN);

  state_t      state_q, state_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_start_q, tx_start_d;
  logic        underrun_q, underrun_d;
  logic        abort_q, abort_d;
  logic        flush_ph_q, flush_ph_d;
  logic        adc_bg_q, adc_bg_d;
  logic        busy_q, busy_d;
  logic        tx_busy, tx_done, abort_now;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return SYNC;
      2'd1:    return CH_ID;
      2'd2:    return LEN16[15:8];
      default: return LEN16[7:0];
    endcase
  endfunction

  // Capture abandoned mid-frame: remembered until the frame closes.
  assign abort_now = abort_q || (!ADC_end && (state_q inside {HDR, RD, CAP, SEND}));

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    underrun_d = underrun_q;
    abort_d    = abort_now;
    flush_ph_d = flush_ph_q;
    if (abort_now) underrun_d = 1'b1;
    case (state_q)
      IDLE: if (ADC_end && !empty) begin
        cnt_d      = '0;
        csum_d     = '0;
        underrun_d = 1'b0;
        abort_d    = 1'b0;
        hdr_idx_d  = 3'd0;
        state_d    = HDR;
      end
      HDR: if (hdr_idx_q == 3'd4) begin
        if (tx_done) begin
          hdr_idx_d = 3'd0;
          state_d   = abort_now ? TAIL : RD;
        end
      end else if (!tx_busy && !tx_start_q) begin
        if (abort_now) begin
          hdr_idx_d = 3'd0;
          state_d   = TAIL;
        end else begin
          tx_byte_d  = hdr_byte(hdr_idx_q[1:0]);
          tx_start_d = 1'b1;
          hdr_idx_d  = hdr_idx_q + 3'd1;
        end
      end
      RD: if (abort_now) begin
        hdr_idx_d = 3'd0;
        state_d   = TAIL;
      end else if (!empty) begin
        state_d = CAP;
      end else begin
        underrun_d = 1'b1;
        tx_byte_d  = 8'h00;
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      CAP: begin
        tx_byte_d  = fifo_q;
        csum_d     = csum_q + fifo_q;
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND: if (tx_done) begin
        cnt_d = cnt_q + 16'd1;
        if (abort_now || (cnt_d == LEN16)) begin
          hdr_idx_d = 3'd0;
          state_d   = TAIL;
        end else begin
          state_d = RD;
        end
      end
      TAIL: if (hdr_idx_q == 3'd0) begin
        if (!tx_busy && !tx_start_q) begin
          tx_byte_d  = csum_q;
          tx_start_d = 1'b1;
          hdr_idx_d  = 3'd1;
        end
      end else if (tx_done) begin
        flush_ph_d = 1'b0;
        state_d    = FLUSH;
      end
      FLUSH: begin
        flush_ph_d = !flush_ph_q;
        if (empty) state_d = REARM;
      end
      REARM: if (!ADC_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    adc_bg_d = (state_d == REARM);
    busy_d   = (state_d != IDLE);
  end

  // Sequencer registers; reset aborts any frame in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      hdr_idx_q  <= 3'd0;
      cnt_q      <= '0;
      csum_q     <= '0;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      flush_ph_q <= 1'b0;
      adc_bg_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
      flush_ph_q <= flush_ph_d;
      adc_bg_q   <= adc_bg_d;
      busy_q     <= busy_d;
    end
  end

  // Reads are gated by the live empty flag so a read never hits an empty FIFO.
  assign rdreq    = !empty && (((state_q == RD) && !abort_now) ||
                               ((state_q == FLUSH) && !flush_ph_q));
  assign ADC_bg   = adc_bg_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

  uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .tx_start (tx_start_q),
    .tx_data  (tx_byte_q),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .uart_tx  (uart_tx)
  );

endmodule

// File: tb/tb_adc_frame_uplink.sv
// tb/tb_adc_frame_uplink.sv - self-checking bench for adc_frame_uplink
module tb_adc_frame_uplink;

  localparam int          FLEN   = 8;
  localparam logic [15:0] FLEN16 = 16'(FLEN);
  localparam logic [7:0]  CH     = 8'h03;
  localparam int          NBYTES = FLEN + 5;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       ADC_end = 1'b0;
  logic       empty;
  logic [7:0] fifo_q = 8'h00;
  logic       rdreq, ADC_bg, uart_tx, busy, underrun;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  adc_frame_uplink #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .FRAME_LEN(FLEN),
    .CH_ID    (CH),
    .SYNC     (8'hA5)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .ADC_end (ADC_end),
    .empty   (empty),
    .fifo_q  (fifo_q),
    .rdreq   (rdreq),
    .ADC_bg  (ADC_bg),
    .uart_tx (uart_tx),
    .busy    (busy),
    .underrun(underrun)
  );

  // FIFO model, normal mode: data appears the cycle after the read strobe.
  logic [7:0] fmem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, rd_cnt = 0, rd_empty_cnt = 0;
  assign empty = (rd_ptr == wr_ptr);
  always @(posedge Clk) begin
    if (rdreq === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      if (empty) rd_empty_cnt <= rd_empty_cnt + 1;
      else begin
        fifo_q <= fmem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Capture-block model: raise/drop on request, clear when re-armed and drained.
  int start_req = 0, start_ack = 0, drop_req = 0, drop_ack = 0;
  always @(posedge Clk) begin
    if (drop_req != drop_ack) begin
      ADC_end  <= 1'b0;
      drop_ack <= drop_req;
    end else if (start_req != start_ack) begin
      ADC_end   <= 1'b1;
      start_ack <= start_req;
    end else if (ADC_bg === 1'b1 && empty) begin
      ADC_end <= 1'b0;
    end
  end

  // UART receiver: every bit must hold for exactly 10 cycles.
  logic [7:0] rx_mem [0:511];
  int         rx_gap [0:511];
  int         rx_cnt = 0, mon_cyc = 0, mon_gap = 999, mon_bad = 0, bg_bad = 0;
  bit         mon_act = 1'b0;
  logic [9:0] mon_bits = '0;
  always @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mon_act <= 1'b0;
      mon_gap <= 999;
    end else begin
      if (ADC_bg === 1'b1 && !empty) bg_bad <= bg_bad + 1;
      if (!mon_act) begin
        if (uart_tx === 1'b0) begin
          mon_act     <= 1'b1;
          mon_cyc     <= 1;
          mon_bits[0] <= 1'b0;
          rx_gap[rx_cnt] <= mon_gap;
        end else if (mon_gap < 999) begin
          mon_gap <= mon_gap + 1;
        end
      end else begin
        if (mon_cyc % 10 == 0) mon_bits[mon_cyc / 10] <= uart_tx;
        else if (uart_tx !== mon_bits[mon_cyc / 10]) mon_bad <= mon_bad + 1;
        if (mon_cyc == 99) begin
          if (mon_bits[9] !== 1'b1 || uart_tx !== 1'b1) mon_bad <= mon_bad + 1;
          rx_mem[rx_cnt] <= mon_bits[8:1];
          rx_cnt  <= rx_cnt + 1;
          mon_act <= 1'b0;
          mon_gap <= 0;
        end else begin
          mon_cyc <= mon_cyc + 1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] pre [0:31];
  int npre;

  task automatic preload();
    for (int i = 0; i < npre; i++) begin
      fmem[wr_ptr] = pre[i];
      wr_ptr++;
    end
  endtask

  // Full frame against the reference: header, samples padded with 00, mod-256 sum.
  task automatic run_frame(input string tag);
    int rx0, rd0, re0, bad0, bgb0, t;
    logic [7:0] exp_b [0:NBYTES-1];
    logic [7:0] s, sum;
    check_eq({tag, ".idle_line"}, uart_tx, 1);
    rx0 = rx_cnt; rd0 = rd_cnt; re0 = rd_empty_cnt; bad0 = mon_bad; bgb0 = bg_bad;
    preload();
    exp_b[0] = 8'hA5;
    exp_b[1] = CH;
    exp_b[2] = FLEN16[15:8];
    exp_b[3] = FLEN16[7:0];
    sum = 8'h00;
    for (int i = 0; i < FLEN; i++) begin
      s = (i < npre) ? pre[i] : 8'h00;
      exp_b[4 + i] = s;
      sum = sum + s;
    end
    exp_b[NBYTES - 1] = sum;
    start_req++;
    t = 0;
    while (busy !== 1'b1 && t < 20) begin @(negedge Clk); t++; end
    check_eq({tag, ".busy_rise"}, busy, 1);
    t = 0;
    while (busy !== 1'b0 && t < 4000) begin @(negedge Clk); t++; end
    check_eq({tag, ".busy_fall"}, busy, 0);
    repeat (3) @(negedge Clk);
    check_eq({tag, ".nbytes"}, rx_cnt - rx0, NBYTES);
    for (int k = 0; k < NBYTES; k++) begin
      check_eq($sformatf("%s.byte%0d", tag, k), rx_mem[rx0 + k], exp_b[k]);
      if (k > 0) check_eq($sformatf("%s.gap%0d", tag, k), rx_gap[rx0 + k] <= 3, 1);
    end
    check_eq({tag, ".underrun"}, underrun, (npre < FLEN) ? 1 : 0);
    check_eq({tag, ".rdreq_cnt"}, rd_cnt - rd0, npre);
    check_eq({tag, ".rd_empty"}, rd_empty_cnt - re0, 0);
    check_eq({tag, ".bit_timing"}, mon_bad - bad0, 0);
    check_eq({tag, ".bg_early"}, bg_bad - bgb0, 0);
    check_eq({tag, ".adc_bg_low"}, ADC_bg, 0);
    check_eq({tag, ".adc_end_low"}, ADC_end, 0);
    check_eq({tag, ".fifo_empty"}, empty, 1);
  endtask

  initial begin
    int t, rx0, rd0;
    bit seen;
    repeat (3) @(negedge Clk);
    check_eq("rst.uart_tx", uart_tx, 1);
    check_eq("rst.rdreq", rdreq, 0);
    check_eq("rst.adc_bg", ADC_bg, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.underrun", underrun, 0);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);

    npre = 8;
    for (int i = 0; i < 8; i++) pre[i] = 8'(i + 1);
    run_frame("t1");

    npre = 5;
    for (int i = 0; i < 5; i++) pre[i] = 8'hFF;
    run_frame("t2");

    npre = 11;
    for (int i = 0; i < 11; i++) pre[i] = 8'h10;
    run_frame("t3");

    rx0 = rx_cnt; rd0 = rd_cnt; seen = 1'b0;
    start_req++;
    repeat (3) @(negedge Clk);
    drop_req++;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (busy !== 1'b0 || uart_tx !== 1'b1) seen = 1'b1;
    end
    check_eq("t6.stays_idle", seen, 0);
    check_eq("t6.rdreq_cnt", rd_cnt - rd0, 0);
    check_eq("t6.nbytes", rx_cnt - rx0, 0);

    for (int r = 0; r < 5; r++) begin
      npre = $urandom_range(1, 12);
      for (int i = 0; i < npre; i++) pre[i] = 8'($urandom);
      run_frame($sformatf("rnd%0d", r));
    end

    npre = 8;
    for (int i = 0; i < 8; i++) pre[i] = 8'($urandom);
    preload();
    rx0 = rx_cnt;
    start_req++;
    t = 0;
    while (rx_cnt < rx0 + 6 && t < 3000) begin @(negedge Clk); t++; end
    check_eq("t5.reach_sample3", rx_cnt - rx0 >= 6, 1);
    t = 0;
    while (uart_tx !== 1'b0 && t < 200) begin @(negedge Clk); t++; end
    check_eq("t5.start_bit", uart_tx, 0);
    repeat (55) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check_eq("t5.uart_tx", uart_tx, 1);
    check_eq("t5.rdreq", rdreq, 0);
    check_eq("t5.adc_bg", ADC_bg, 0);
    check_eq("t5.busy", busy, 0);
    drop_req++;
    wr_ptr = rd_ptr;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    check_eq("t5.adc_end_dropped", ADC_end, 0);
    npre = 8;
    for (int i = 0; i < 8; i++) pre[i] = 8'($urandom);
    run_frame("t5_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
